// File: rtl/gba_waitstate_ctrl.sv
// GBA bus timing stage: decodes the region of one CPU access, stalls for the
// GBA-accurate cycle count (bus width, WAITCNT, N/S type), then issues a
// single-cycle memory strobe and returns read data with a ready pulse.
module gba_waitstate_ctrl #(
  parameter int ROM_PAGE_BITS = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_seq,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic [15:0] waitcnt,
  output logic        mem_req,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  cnt, cnt_next;
  logic        accept;
  logic        wait_end;
  logic        acc_mapped;

  // Sequential-access history
  logic [31:0] last_addr;
  logic [2:0]  last_step;
  logic [3:0]  last_region;
  logic        last_valid;

  logic [3:0]  nib;
  logic [3:0]  region_now;
  logic        is_rom;
  logic        contiguous;
  logic        seq_eff;
  logic [4:0]  cycles_now;

  // WAITCNT 2-bit wait selector: {4,3,2,8}
  function automatic logic [4:0] ws_wait(input logic [1:0] sel);
    case (sel)
      2'd0:    return 5'd4;
      2'd1:    return 5'd3;
      2'd2:    return 5'd2;
      default: return 5'd8;
    endcase
  endfunction

  // Mirrored ROM/SRAM windows collapse to one region id so 0x8/0x9 etc. match
  function automatic logic [3:0] region_id(input logic [3:0] n);
    if (n >= 4'h8 && n <= 4'hD) return {n[3:1], 1'b0};
    if (n >= 4'hE)              return 4'hE;
    return n;
  endfunction

  // Total cycle count of one access; a unit is 1 + waits
  function automatic logic [4:0] access_cycles(input logic [3:0]  n,
                                               input logic [1:0]  size,
                                               input logic        seq,
                                               input logic [15:0] wc);
    logic [4:0] n_unit;
    logic [4:0] s_unit;
    logic       bus16;
    logic [4:0] first;
    n_unit = 5'd1;
    s_unit = 5'd1;
    bus16  = 1'b0;
    case (n)
      4'h2: begin
        bus16  = 1'b1;
        n_unit = 5'd3;
        s_unit = 5'd3;
      end
      4'h5, 4'h6, 4'h7: bus16 = 1'b1;
      4'h8, 4'h9: begin
        bus16  = 1'b1;
        n_unit = 5'd1 + ws_wait(wc[3:2]);
        s_unit = wc[4] ? 5'd2 : 5'd3;
      end
      4'hA, 4'hB: begin
        bus16  = 1'b1;
        n_unit = 5'd1 + ws_wait(wc[6:5]);
        s_unit = wc[7] ? 5'd2 : 5'd5;
      end
      4'hC, 4'hD: begin
        bus16  = 1'b1;
        n_unit = 5'd1 + ws_wait(wc[9:8]);
        s_unit = wc[10] ? 5'd2 : 5'd9;
      end
      4'hE, 4'hF: begin
        n_unit = 5'd1 + ws_wait(wc[1:0]);
        s_unit = n_unit;
      end
      default: begin
        n_unit = 5'd1;
        s_unit = 5'd1;
      end
    endcase
    first = seq ? s_unit : n_unit;
    // A word on a 16-bit bus takes a second, always-sequential unit
    if (bus16 && size[1]) return first + s_unit;
    return first;
  endfunction

  // Decode of the access being offered and its effective N/S type
  always_comb begin
    nib        = cpu_addr[27:24];
    region_now = region_id(nib);
    is_rom     = (nib >= 4'h8) && (nib <= 4'hD);
    contiguous = last_valid
                 && (cpu_addr == last_addr + {29'd0, last_step})
                 && (region_now == last_region)
                 && !(is_rom && (cpu_addr[ROM_PAGE_BITS-1:0] == '0));
    seq_eff    = cpu_seq && contiguous;
    cycles_now = access_cycles(nib, cpu_size, seq_eff, waitcnt);
  end

  // FSM state and wait counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // FSM next state, counter and strobes
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    wait_end   = 1'b0;
    mem_req    = 1'b0;
    cpu_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          accept     = 1'b1;
          cnt_next   = cycles_now - 5'd1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 5'd0) begin
          wait_end   = 1'b1;
          mem_req    = acc_mapped && !reset;
          state_next = DONE;
        end else begin
          cnt_next = cnt - 5'd1;
        end
      end
      DONE: begin
        cpu_ready  = !reset;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Access capture, read-data latch and sequential history
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_write   <= 1'b0;
      mem_addr    <= 32'd0;
      mem_size    <= 2'd0;
      mem_wdata   <= 32'd0;
      acc_mapped  <= 1'b0;
      cpu_rdata   <= 32'd0;
      last_addr   <= 32'd0;
      last_step   <= 3'd0;
      last_region <= 4'd0;
      last_valid  <= 1'b0;
    end else begin
      if (accept) begin
        mem_write   <= cpu_write;
        mem_addr    <= cpu_addr;
        mem_size    <= cpu_size;
        mem_wdata   <= cpu_wdata;
        acc_mapped  <= (nib != 4'h1);
        last_addr   <= cpu_addr;
        last_step   <= (cpu_size == 2'd0) ? 3'd1 : (cpu_size == 2'd1) ? 3'd2 : 3'd4;
        last_region <= region_now;
        last_valid  <= 1'b1;
      end
      if (wait_end && !mem_write) begin
        cpu_rdata <= acc_mapped ? mem_rdata : 32'd0;
      end
    end
  end

endmodule

// File: doc/gba_waitstate_ctrl.md
# gba_waitstate_ctrl

Bus timing stage between the ARM7TDMI core's memory port and the memory map/MMU. It accepts one CPU access at a time and decodes the GBA region from the address. It computes the region's access length from the bus width, the `WAITCNT` settings and the N/S access type. It holds the CPU stalled for that many cycles, then issues one single-cycle request to memory and returns the captured read data with a one-cycle `ready` pulse. This gives the CPU core GBA-accurate cycle counts without the memory map modelling timing.

## Interface
Parameters:
- `ROM_PAGE_BITS`, default 17: ROM sequential bursts break on a 2^17-byte (128 KiB) boundary.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high; one clock; all state cleared on the rising edge while high.
- `cpu_req` input 1: access request, held with all fields stable until `cpu_ready`.
- `cpu_write` input 1: 1 = write.
- `cpu_addr` input 32: byte address.
- `cpu_size` input 2: 0 byte, 1 halfword, 2 word; 3 treated as word.
- `cpu_seq` input 1: CPU marks the access sequential (S) rather than non-sequential (N).
- `cpu_wdata` input 32: write data.
- `cpu_rdata` output 32: read data, valid when `cpu_ready`; holds its last value otherwise.
- `cpu_ready` output 1: one-cycle completion pulse.
- `waitcnt` input 16: WAITCNT register value, sampled at accept.
- `mem_req` output 1: one-cycle strobe to the memory map.
- `mem_write`, `mem_addr[31:0]`, `mem_size[1:0]`, `mem_wdata[31:0]` outputs: captured access fields, valid while `mem_req`.
- `mem_rdata` input 32: combinational read data from memory, sampled in the `mem_req` cycle.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE** with `cpu_req`:
  - capture addr, size, write, wdata and the effective seq flag;
  - compute the total cycle count C;
  - load counter = C-1 and go to WAIT.
- **WAIT**:
  - if counter == 0, assert `mem_req` with the captured fields, latch `mem_rdata` (on reads) into `cpu_rdata`, and go to DONE;
  - otherwise decrement the counter.
- **DONE**: assert `cpu_ready` and go to IDLE.
- Regions, selected by `addr[27:24]`; a "unit" costs 1 + waits cycles:
  - 0x0 BIOS: 32-bit bus, 0 waits.
  - 0x2 EWRAM: 16-bit bus, 2 waits per unit.
  - 0x3 IWRAM: 32-bit bus, 0 waits.
  - 0x4 IO: 32-bit bus, 0 waits.
  - 0x5 palette, 0x6 VRAM, 0x7 OAM: 16-bit bus, 0 waits.
  - 0x8/0x9 WS0, 0xA/0xB WS1, 0xC/0xD WS2: 16-bit bus. N waits are indexed by `waitcnt[3:2]`, `[6:5]` and `[9:8]` into {4,3,2,8}. S waits: WS0 `[4]` selects {2,1}; WS1 `[7]` selects {4,1}; WS2 `[10]` selects {8,1}.
  - 0xE/0xF SRAM: 8-bit bus, waits from `waitcnt[1:0]` into {4,3,2,8}; every access costs one unit regardless of size.
  - 0x1 unmapped: 1 cycle, `mem_req` suppressed, `cpu_rdata` = 0.
- Cost of C:
  - byte/halfword on a 16- or 32-bit bus, and any access on a 32-bit bus: one unit;
  - word on a 16-bit bus: two units; the second is always S.
- Effective seq:
  - `cpu_seq` is honoured only if `addr == last_addr + last_step`, the region is the same, and (for ROM) `addr[ROM_PAGE_BITS-1:0] != 0`; otherwise the access is forced to N.
  - `last_addr` and `last_step` (1/2/4 by size) update at every accept; both reset to 0, with a "no previous" flag set.
- Counter width: 5 bits (max C = 2*(1+8) = 18).

## Timing
- Reset values: `cpu_ready`=0, `mem_req`=0, `cpu_rdata`=0, `mem_*` fields 0, state IDLE, counter 0.
- Request first seen in cycle 0 (IDLE) → `mem_req` in cycle C → `cpu_ready` in cycle C+1. Minimum latency is 2 cycles (C=1).
- `cpu_req` is ignored in WAIT and DONE.
- Back-to-back requests: the next request is sampled in the IDLE cycle after DONE, so there is one idle cycle between accesses.
- `mem_req` asserts exactly once per access and never in the same cycle as `cpu_ready`.
- Writes: `cpu_rdata` unchanged.
- `waitcnt` changes after accept do not affect the access in flight.
- Reset mid-access: the FSM returns to IDLE next cycle, with no `mem_req` and no `cpu_ready` for the aborted access, and the seq history is cleared.

## Test plan
- IWRAM word read at 0x03000000, `mem_rdata`=0xDEADBEEF → `mem_req` cycle 1, `cpu_ready` cycle 2, `cpu_rdata`=0xDEADBEEF.
- `waitcnt`=0x0000, ROM word N read at 0x08000000 → C=(1+4)+(1+2)=8, `cpu_ready` cycle 9. Then a seq word at 0x08000004 → C=6. Then seq=1 at 0x08000010 (non-contiguous) → forced N, C=8.
- `waitcnt`=0x0014 (WS0 N=3, S=1), ROM word N → C=6. A seq halfword at 0x0801FFFE followed by a seq access at 0x08020000 → the second is forced N (page break), C=4.
- EWRAM halfword write 0x02000000 → C=3. EWRAM word → C=6. SRAM byte with `waitcnt[1:0]`=3 → C=9.
- Unmapped read 0x01000000 → no `mem_req`, `cpu_ready` cycle 2, `cpu_rdata`=0.
- Reset asserted in cycle 3 of a C=8 ROM access → no `mem_req` or `cpu_ready` follows. A new IWRAM read after reset completes in 2 cycles as N.
